// File: rtl/voice_allocator_if.sv
// ---------------------------------------------------------------------------
// voice_allocator_if
//   Request channel from the song reader into the voice allocator.
//   A request is taken on any cycle where req_valid && req_ready.
//
//   Signals
//     req_valid     requester -> allocator   note request valid
//     req_note      requester -> allocator   requested note code
//     req_duration  requester -> allocator   requested duration
//     req_ready     allocator -> requester   allocator can take a request
//
//   Modports
//     master  song reader side (drives the request)
//     slave   voice allocator side (drives req_ready)
// ---------------------------------------------------------------------------
interface voice_allocator_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic              req_valid;
    logic [NOTE_W-1:0] req_note;
    logic [DUR_W-1:0]  req_duration;
    logic              req_ready;

    modport master (
        output req_valid,
        output req_note,
        output req_duration,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_note,
        input  req_duration,
        output req_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//   Arbitrates note requests from the song reader across a pool of note-player
//   voices. A free voice is chosen round-robin and receives a one-hot, 1-cycle
//   load strobe together with the registered note/duration. Voices loaded
//   since the last frame advance are tracked so a chord never reuses a voice.
//
//   Optional feature macro: VOICE_STEAL_EN
//     When defined, each voice keeps a saturating age counter and a request
//     that finds no idle voice steals the oldest voice that is neither used
//     in this frame nor guarded. When undefined, such a request is dropped.
//
//   Ports
//     clk             system clock
//     reset           asynchronous, active-low reset
//     play            1 = accept requests, 0 = hold off new requests
//     req             request channel (voice_allocator_if.slave)
//     advance         frame-boundary pulse; clears the used mask
//     voice_done      per-voice idle flag from the players
//     voice_load      one-hot, 1-cycle load strobe
//     voice_note      note for the loaded voice (valid with voice_load)
//     voice_duration  duration for the loaded voice (valid with voice_load)
//     used_mask       voices loaded since the last advance
//     dropped         1-cycle pulse: an accepted request got no voice
//     stolen          1-cycle pulse: a busy voice was overwritten
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int AGE_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    voice_allocator_if.slave      req,
    input  logic                  advance,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic [NUM_VOICES-1:0] used_mask,
    output logic                  dropped,
    output logic                  stolen
);
    localparam int PTR_W = $clog2(NUM_VOICES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        rr_ptr_reg;
    logic [NUM_VOICES-1:0]   guard_reg;     // last cycle's load: player done flag lags
    logic [NUM_VOICES-1:0]   used_eff;
    logic [NUM_VOICES-1:0]   free;
    logic                    accept;
    logic                    rr_found;
    logic [PTR_W-1:0]        rr_idx;
    logic                    grant_any;
    logic                    grant_steal;
    logic [PTR_W-1:0]        grant_idx;
    logic [NUM_VOICES-1:0]   grant_vec;

    // Ready is forced low while reset is held so every output reads 0.
    assign req.req_ready = reset && play && (state_reg == IDLE);
    assign accept        = req.req_valid && req.req_ready;
    assign used_eff      = advance ? '0 : used_mask;
    assign free          = voice_done & ~guard_reg & ~used_eff;

    // Round-robin scan starting at rr_ptr; first free voice wins.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
            if (!rr_found && free[idx]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'(idx);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0]      age_reg [NUM_VOICES];
    logic [NUM_VOICES-1:0] eligible;
    logic                  steal_found;
    logic [PTR_W-1:0]      steal_idx;
    logic [AGE_W-1:0]      best_age;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_age
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    age_reg[gi] <= '0;
                else if (voice_load[gi])
                    age_reg[gi] <= '0;
                else if (age_reg[gi] != AGE_MAX)
                    age_reg[gi] <= age_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign eligible = ~used_eff & ~guard_reg;

    // Oldest eligible voice; strict compare in ascending order keeps ties at
    // the lowest index.
    always_comb begin
        steal_found = 1'b0;
        steal_idx   = '0;
        best_age    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (eligible[i] && (!steal_found || age_reg[i] > best_age)) begin
                steal_found = 1'b1;
                steal_idx   = PTR_W'(i);
                best_age    = age_reg[i];
            end
        end
    end

    assign grant_any   = rr_found || steal_found;
    assign grant_steal = !rr_found && steal_found;
    assign grant_idx   = rr_found ? rr_idx : steal_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stolen <= 1'b0;
        else
            stolen <= accept && grant_steal;
    end
`else
    // Age width only matters to the stealing variant.
    localparam int unused_age_w = AGE_W;

    assign grant_any   = rr_found;
    assign grant_steal = 1'b0;
    assign grant_idx   = rr_idx;
    assign stolen      = 1'b0;
`endif

    assign grant_vec = grant_any ? (NUM_VOICES'(1) << grant_idx) : '0;

    // FSM: one ISSUE cycle after every accept limits throughput to 1 per 2.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            guard_reg      <= '0;
            used_mask      <= '0;
            voice_load     <= '0;
            voice_note     <= '0;
            voice_duration <= '0;
            dropped        <= 1'b0;
        end else begin
            state_reg  <= state_next;
            guard_reg  <= voice_load;
            used_mask  <= used_eff | voice_load;
            voice_load <= accept ? grant_vec : '0;
            dropped    <= accept && !grant_any;
            if (accept && grant_any) begin
                rr_ptr_reg     <= (grant_idx == PTR_W'(NUM_VOICES - 1)) ? '0
                                                                       : grant_idx + 1'b1;
                voice_note     <= req.req_note;
                voice_duration <= req.req_duration;
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
//   Directed, table-driven bench for voice_allocator (3 voices, 6-bit note
//   and duration). Each table row is one request with its expected load
//   strobe, held note/duration, drop flag and used mask one cycle later.
//   Hand-written sequences cover reset, play hold-off, reset during ISSUE
//   and (with VOICE_STEAL_EN) the oldest-voice steal.
// ---------------------------------------------------------------------------
module tb_voice_allocator;
    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          play = 1'b0;
    logic          advance = 1'b0;
    logic [NV-1:0] voice_done = '0;
    logic [NV-1:0] voice_load;
    logic [NW-1:0] voice_note;
    logic [DW-1:0] voice_duration;
    logic [NV-1:0] used_mask;
    logic          dropped;
    logic          stolen;

    voice_allocator_if #(.NOTE_W(NW), .DUR_W(DW)) rif ();

    voice_allocator #(
        .NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .AGE_W(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .play           (play),
        .req            (rif),
        .advance        (advance),
        .voice_done     (voice_done),
        .voice_load     (voice_load),
        .voice_note     (voice_note),
        .voice_duration (voice_duration),
        .used_mask      (used_mask),
        .dropped        (dropped),
        .stolen         (stolen)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          adv;
        logic [NV-1:0] done;
        logic [NW-1:0] note;
        logic [DW-1:0] dur;
        logic [NV-1:0] exp_load;
        logic          exp_drop;
        logic [NW-1:0] exp_note;
        logic [DW-1:0] exp_dur;
        logic [NV-1:0] exp_used;
    } vec_t;

    vec_t vecs [9];

    // Present one request at a negedge, wait (bounded) for ready, let the
    // accept edge pass and return 1 ns into the N+1 cycle.
    task automatic req_txn(input logic adv, input logic [NV-1:0] done,
                           input logic [NW-1:0] note, input logic [DW-1:0] dur);
        @(negedge clk);
        play             = 1'b1;
        advance          = adv;
        voice_done       = done;
        rif.req_valid    = 1'b1;
        rif.req_note     = note;
        rif.req_duration = dur;
        for (int k = 0; k < 8 && !rif.req_ready; k++) @(negedge clk);
        check("req_ready_before_accept", 32'(rif.req_ready), 32'd1);
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        advance       = 1'b0;
    endtask

    initial begin
        rif.req_valid    = 1'b0;
        rif.req_note     = '0;
        rif.req_duration = '0;

        //            adv done    note  dur   load    drop note  dur   used
        vecs[0] = '{1'b0, 3'b111, 6'd5,  6'd10, 3'b001, 1'b0, 6'd5,  6'd10, 3'b001};
        vecs[1] = '{1'b0, 3'b111, 6'd7,  6'd12, 3'b010, 1'b0, 6'd7,  6'd12, 3'b011};
        vecs[2] = '{1'b0, 3'b111, 6'd9,  6'd14, 3'b100, 1'b0, 6'd9,  6'd14, 3'b111};
        vecs[3] = '{1'b0, 3'b111, 6'd11, 6'd16, 3'b000, 1'b1, 6'd9,  6'd14, 3'b111};
        vecs[4] = '{1'b1, 3'b111, 6'd13, 6'd18, 3'b001, 1'b0, 6'd13, 6'd18, 3'b001};
        vecs[5] = '{1'b1, 3'b101, 6'd20, 6'd21, 3'b100, 1'b0, 6'd20, 6'd21, 3'b100};
        vecs[6] = '{1'b0, 3'b101, 6'd22, 6'd23, 3'b001, 1'b0, 6'd22, 6'd23, 3'b101};
        vecs[7] = '{1'b0, 3'b111, 6'd24, 6'd25, 3'b010, 1'b0, 6'd24, 6'd25, 3'b111};
        vecs[8] = '{1'b0, 3'b111, 6'd26, 6'd27, 3'b000, 1'b1, 6'd24, 6'd25, 3'b111};

        // Reset state, with play high to show ready is still held low.
        play       = 1'b1;
        voice_done = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_voice_load", 32'(voice_load), 32'd0);
        check("rst_used_mask",  32'(used_mask),  32'd0);
        check("rst_dropped",    32'(dropped),    32'd0);
        check("rst_stolen",     32'(stolen),     32'd0);
        check("rst_note",       32'(voice_note), 32'd0);
        check("rst_duration",   32'(voice_duration), 32'd0);
        check("rst_req_ready",  32'(rif.req_ready),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            req_txn(vecs[i].adv, vecs[i].done, vecs[i].note, vecs[i].dur);
            check($sformatf("v%0d_load", i),     32'(voice_load),     32'(vecs[i].exp_load));
            check($sformatf("v%0d_dropped", i),  32'(dropped),        32'(vecs[i].exp_drop));
            check($sformatf("v%0d_stolen", i),   32'(stolen),         32'd0);
            check($sformatf("v%0d_note", i),     32'(voice_note),     32'(vecs[i].exp_note));
            check($sformatf("v%0d_duration", i), 32'(voice_duration), 32'(vecs[i].exp_dur));
            check($sformatf("v%0d_ready_issue", i), 32'(rif.req_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_load_pulse_end", i), 32'(voice_load), 32'd0);
            check($sformatf("v%0d_drop_pulse_end", i), 32'(dropped),    32'd0);
            check($sformatf("v%0d_used_mask", i),      32'(used_mask),  32'(vecs[i].exp_used));
            $display("vector %0d: note=%0d dur=%0d load=%b dropped=%b used=%b",
                     i, vecs[i].note, vecs[i].dur, vecs[i].exp_load, vecs[i].exp_drop,
                     vecs[i].exp_used);
        end

        // play=0 holds off requests; rr_ptr is 2 after the last grant (voice 1).
        @(negedge clk);
        play             = 1'b0;
        advance          = 1'b1;
        voice_done       = 3'b111;
        rif.req_valid    = 1'b1;
        rif.req_note     = 6'd30;
        rif.req_duration = 6'd31;
        #1;
        check("hold_req_ready", 32'(rif.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_no_load_%0d", k), 32'(voice_load), 32'd0);
        end
        @(negedge clk);
        play = 1'b1;
        #1;
        check("resume_req_ready", 32'(rif.req_ready), 32'd1);
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        advance       = 1'b0;
        check("resume_load", 32'(voice_load), 32'b100);
        check("resume_note", 32'(voice_note), 32'd30);
        $display("play hold-off: resumed grant load=%b", voice_load);
        @(posedge clk);
        #1;

        // Reset in the middle of ISSUE cancels the load at once.
        req_txn(1'b1, 3'b111, 6'd33, 6'd34);
        check("issue_load_before_rst", 32'(voice_load), 32'b001);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_voice_load", 32'(voice_load),     32'd0);
        check("midrst_note",       32'(voice_note),     32'd0);
        check("midrst_duration",   32'(voice_duration), 32'd0);
        check("midrst_used_mask",  32'(used_mask),      32'd0);
        check("midrst_req_ready",  32'(rif.req_ready),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        req_txn(1'b0, 3'b111, 6'd40, 6'd41);
        check("postrst_load", 32'(voice_load), 32'b001);
        check("postrst_note", 32'(voice_note), 32'd40);
        $display("reset during issue: post-reset grant load=%b", voice_load);
        @(posedge clk);
        #1;

`ifdef VOICE_STEAL_EN
        // Load voice 0 late so voices 1 and 2 are equally old and older.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(posedge clk);
        req_txn(1'b0, 3'b111, 6'd1, 6'd2);
        check("steal_setup_load", 32'(voice_load), 32'b001);
        repeat (40) @(posedge clk);
        req_txn(1'b1, 3'b000, 6'd3, 6'd4);
        check("steal_load",    32'(voice_load), 32'b010);
        check("steal_stolen",  32'(stolen),     32'd1);
        check("steal_dropped", 32'(dropped),    32'd0);
        check("steal_note",    32'(voice_note), 32'd3);
        $display("steal: load=%b stolen=%b dropped=%b", voice_load, stolen, dropped);
        @(posedge clk);
        #1;
        check("steal_pulse_end", 32'(stolen), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
